// File: rtl/mux_cfg_pkg.sv
// Shared command codes and loader state encoding for the mux configuration loader.
package mux_cfg_pkg;

    localparam logic [7:0] CMD_SET      = 8'hA5;
    localparam logic [7:0] CMD_COMMIT   = 8'h5A;
    localparam logic [7:0] CMD_IDENTITY = 8'hFF;
    localparam logic [7:0] CMD_NOP      = 8'h00;

    // Encodings kept numerically identical to the legacy constants.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GET_DST = 2'd1;
    localparam logic [1:0] ST_GET_SRC = 2'd2;
    localparam logic [1:0] ST_FILL    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_GET_DST = ST_GET_DST,
        S_GET_SRC = ST_GET_SRC,
        S_FILL    = ST_FILL
    } state_t;

endpackage

// File: rtl/mux_cfg_table.sv
// Shadow/active routing table pair: indexed shadow write, bulk commit to active,
// both tables reset to the identity routing.
module mux_cfg_table
    import mux_cfg_pkg::*;
#(
    parameter int  INPUT_COUNT  = 16,
    parameter int  OUTPUT_COUNT = 16,
    localparam int SEL_W        = $clog2(INPUT_COUNT),
    localparam int IDX_W        = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_wr_en,
    input  logic [IDX_W-1:0]                i_wr_idx,
    input  logic [SEL_W-1:0]                i_wr_data,
    input  logic                            i_commit,
    output logic [0:SEL_W*OUTPUT_COUNT-1]   o_active
);

    logic [SEL_W-1:0] r_shadow [OUTPUT_COUNT];
    logic [SEL_W-1:0] r_active [OUTPUT_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
                r_shadow[i] <= SEL_W'(i % INPUT_COUNT);
                r_active[i] <= SEL_W'(i % INPUT_COUNT);
            end
        end else begin
            if (i_wr_en) begin
                r_shadow[i_wr_idx] <= i_wr_data;
            end
            if (i_commit) begin
                for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // Field i sits at ascending bit numbers, so its MSB lands on the lowest index.
    always_comb begin
        o_active = '0;
        for (int unsigned i = 0; i < OUTPUT_COUNT; i++) begin
            o_active[i*SEL_W +: SEL_W] = r_active[i];
        end
    end

endmodule

// File: rtl/mux_config_loader.sv
// Byte-stream command parser that builds a pin-mux routing table in shadow storage
// and publishes it to the selectors on COMMIT.
module mux_config_loader
    import mux_cfg_pkg::*;
#(
    parameter int  INPUT_COUNT  = 16,
    parameter int  OUTPUT_COUNT = 16,
    parameter int  TIMEOUT      = 1000,
    localparam int SEL_W        = $clog2(INPUT_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [0:SEL_W*OUTPUT_COUNT-1]   selectors,
    output logic                            commit_pulse,
    output logic                            err_pulse,
    output logic                            busy
);

    localparam int IDX_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [7:0]         r_dst;
    logic [TMO_W-1:0]   r_tmo;
    logic [IDX_W-1:0]   r_fill_k;
    logic               r_commit;
    logic               r_err;

    logic               w_accept;
    logic               w_pair_ok;
    logic               w_tmo_hit;
    logic               w_wr_en;
    logic               w_commit;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [SEL_W-1:0]   w_wr_data;

    assign in_ready     = (r_state != S_FILL);
    assign busy         = (r_state != S_IDLE);
    assign commit_pulse = r_commit;
    assign err_pulse    = r_err;
    assign w_accept     = in_valid && in_ready;
    assign w_pair_ok    = (32'(r_dst) < OUTPUT_COUNT) && (32'(in_data) < INPUT_COUNT);
    assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT - 1));

    // SET and FILL never overlap in time, so they share the single shadow write port.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = r_dst[IDX_W-1:0];
        w_wr_data = in_data[SEL_W-1:0];
        w_commit  = (r_state == S_IDLE) && w_accept && (in_data == CMD_COMMIT);
        if (r_state == S_FILL) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_fill_k;
            w_wr_data = SEL_W'(32'(r_fill_k) % INPUT_COUNT);
        end else if (r_state == S_GET_SRC) begin
            w_wr_en   = w_accept && w_pair_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_dst    <= '0;
            r_tmo    <= '0;
            r_fill_k <= '0;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (in_data)
                            CMD_SET: begin
                                r_tmo   <= '0;
                                r_state <= S_GET_DST;
                            end
                            CMD_COMMIT:   r_commit <= 1'b1;
                            CMD_IDENTITY: begin
                                r_fill_k <= '0;
                                r_state  <= S_FILL;
                            end
                            CMD_NOP:      ;
                            default:      r_err <= 1'b1;
                        endcase
                    end
                end
                S_GET_DST, S_GET_SRC: begin
                    if (w_accept) begin
                        r_tmo <= '0;
                        if (r_state == S_GET_DST) begin
                            r_dst   <= in_data;
                            r_state <= S_GET_SRC;
                        end else begin
                            r_err   <= !w_pair_ok;
                            r_state <= S_IDLE;
                        end
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_FILL: begin
                    if (r_fill_k == IDX_W'(OUTPUT_COUNT - 1)) begin
                        r_fill_k <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_fill_k <= r_fill_k + IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    mux_cfg_table #(
        .INPUT_COUNT  (INPUT_COUNT),
        .OUTPUT_COUNT (OUTPUT_COUNT)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (w_wr_data),
        .i_commit  (w_commit),
        .o_active  (selectors)
    );

endmodule

// File: tb/tb_mux_config_loader.sv
// Scoreboard bench for mux_config_loader: a command-level model queues expected
// pulses, a negedge monitor pops them and tracks the published routing table.
module tb_mux_config_loader;

    localparam int IC  = 16;
    localparam int OC  = 16;
    localparam int TMO = 1000;
    localparam int SW  = $clog2(IC);
    localparam int VW  = SW * OC;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [0:VW-1]  selectors;
    logic           commit_pulse;
    logic           err_pulse;
    logic           busy;

    mux_config_loader #(
        .INPUT_COUNT  (IC),
        .OUTPUT_COUNT (OC),
        .TIMEOUT      (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .selectors    (selectors),
        .commit_pulse (commit_pulse),
        .err_pulse    (err_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_commit;
        logic [0:VW-1] sel;
    } ev_t;

    ev_t            exp_q[$];
    int             total = 0;
    int             bad = 0;

    // Command-level model: pending bytes of the current SET, shadow table, fill/idle timers.
    int             shadow[OC];
    logic [7:0]     pend[$];
    int             idle_cnt = 0;
    int             fill_left = 0;
    bit             last_acc = 1'b0;

    logic [0:VW-1]  mon_active;
    bit             mon_reset_req = 1'b0;
    bit             mon_on = 1'b0;

    function automatic void check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [0:VW-1] identity_vec();
        logic [0:VW-1] v;
        for (int i = 0; i < OC; i++) v[i*SW +: SW] = SW'(i % IC);
        return v;
    endfunction

    function automatic logic [0:VW-1] shadow_vec();
        logic [0:VW-1] v;
        for (int i = 0; i < OC; i++) v[i*SW +: SW] = SW'(shadow[i]);
        return v;
    endfunction

    function automatic void push_err();
        ev_t e;
        e.is_commit = 1'b0;
        e.sel       = '0;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < OC; i++) shadow[i] = i % IC;
        pend.delete();
        idle_cnt  = 0;
        fill_left = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] d);
        ev_t e;
        idle_cnt = 0;
        if (pend.size() == 0) begin
            case (d)
                8'hA5: pend.push_back(d);
                8'h5A: begin
                    e.is_commit = 1'b1;
                    e.sel       = shadow_vec();
                    exp_q.push_back(e);
                end
                8'hFF: begin
                    for (int i = 0; i < OC; i++) shadow[i] = i % IC;
                    fill_left = OC;
                end
                8'h00: ;
                default: push_err();
            endcase
        end else if (pend.size() == 1) begin
            pend.push_back(d);
        end else begin
            if (int'(pend[1]) < OC && int'(d) < IC) shadow[pend[1]] = int'(d);
            else push_err();
            pend.delete();
        end
    endfunction

    // One clock cycle: check levels, drive, let the edge happen, advance the model.
    task automatic cycle(input bit v, input logic [7:0] d);
        bit rdy;
        bit acc;
        rdy = (fill_left == 0);
        check("in_ready", VW'(in_ready), VW'(rdy));
        check("busy", VW'(busy), VW'((pend.size() != 0) || (fill_left > 0)));
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        acc = v && rdy;
        last_acc = acc;
        if (fill_left > 0) fill_left--;
        if (acc) begin
            model_accept(d);
        end else if (pend.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                push_err();
                pend.delete();
                idle_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) cycle(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b);
        int tries;
        tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 100) begin
            cycle(1'b1, b);
            tries++;
        end
        if (!last_acc) check("send_accept", VW'(0), VW'(1));
    endtask

    task automatic do_reset();
        check("queue_empty_before_reset", VW'(exp_q.size()), VW'(0));
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        mon_reset_req = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            ev_t e;
            if (mon_reset_req) begin
                mon_active    = identity_vec();
                mon_reset_req = 1'b0;
            end
            if (commit_pulse === 1'b1 || err_pulse === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", VW'({commit_pulse, err_pulse}), VW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", VW'({commit_pulse, err_pulse}), e.is_commit ? VW'(2) : VW'(1));
                    if (e.is_commit) begin
                        check("commit_sel", selectors, e.sel);
                        mon_active = e.sel;
                    end
                end
            end
            check("selectors", selectors, mon_active);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_reset_req = 1'b1;
        mon_on = 1'b1;

        // Idle after reset: identity routing, idle flags.
        gap(3);

        // Single SET then COMMIT, back-to-back.
        send(8'hA5); send(8'h03); send(8'h0F); send(8'h5A);
        gap(3);

        // Out-of-range destination is rejected.
        do_reset();
        send(8'hA5); send(8'h10); send(8'h02); send(8'h5A);
        gap(3);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h5A);
        send(8'h37); send(8'h00);
        gap(3);

        // Timeout after the destination byte, then a clean retry.
        do_reset();
        send(8'hA5); send(8'h05);
        gap(TMO);
        gap(2);
        send(8'hA5); send(8'h05); send(8'h07); send(8'h5A);
        gap(2);

        // One cycle short of the timeout is still a live command.
        send(8'hA5); gap(TMO - 1); send(8'h09); gap(TMO - 1); send(8'h0C); send(8'h5A);
        gap(2);

        // Non-identity table, committed, then IDENTITY fill followed by COMMIT.
        for (int i = 0; i < OC; i++) begin
            send(8'hA5); send(8'(i)); send(8'((OC - 1 - i) % IC));
        end
        send(8'h5A);
        send(8'hFF);
        send(8'h5A);
        gap(3);

        // Reset mid-SET and mid-FILL.
        send(8'hA5); send(8'h02); send(8'h5A); send(8'hA5); send(8'h01);
        gap(1);
        do_reset();
        gap(2);
        send(8'hA5); send(8'h04); send(8'h08); send(8'h5A); send(8'hFF);
        gap(5);
        do_reset();
        gap(2);

        // Randomized command mix.
        for (int n = 0; n < 1200; n++) begin
            op = $urandom_range(0, 19);
            if (op < 7) begin
                send(8'hA5); gap($urandom_range(0, 1));
                send(8'($urandom_range(0, OC - 1))); gap($urandom_range(0, 1));
                send(8'($urandom_range(0, IC - 1)));
            end else if (op < 9) begin
                send(8'hA5); send(8'($urandom)); send(8'($urandom));
            end else if (op < 13) begin
                send(8'h5A);
            end else if (op == 13) begin
                send(8'hFF);
            end else if (op == 14) begin
                send(8'h00);
            end else if (op == 15) begin
                send(8'($urandom));
            end else if (op < 19) begin
                gap($urandom_range(1, 3));
            end else begin
                gap(1);
                do_reset();
            end
        end

        gap(OC + 4);
        check("queue_empty_at_end", VW'(exp_q.size()), VW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_config_loader.md
MUX_CONFIG_LOADER -- requirements
Module: mux_config_loader

Interface
REQ-001 Parameter INPUT_COUNT, default 16, number of selectable source pins.
REQ-002 Parameter OUTPUT_COUNT, default 16, number of routed output pins.
REQ-003 Parameter TIMEOUT, default 1000, idle cycles allowed between bytes of one command.
REQ-004 Localparam SEL_W = $clog2(INPUT_COUNT), selector field width (4 at defaults).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_data  input  8  command byte stream.
REQ-009 in_valid  input  1  in_data valid; a byte is accepted when in_valid && in_ready at a rising edge.
REQ-010 in_ready  output  1  loader can accept a byte.
REQ-011 selectors  output  [0:SEL_W*OUTPUT_COUNT-1]  active routing table; output i's source index occupies bits [i*SEL_W : (i+1)*SEL_W-1], MSB at lowest bit number; drives the pin mux selectors port directly.
REQ-012 commit_pulse  output  1  one-cycle pulse when the active table is updated.
REQ-013 err_pulse  output  1  one-cycle pulse on any protocol error.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 Loader holds two tables: shadow (written by commands) and active (drives selectors); both registered.
REQ-016 States: IDLE, GET_DST, GET_SRC, FILL.
REQ-017 IDLE, byte 0xA5 (SET) -> GET_DST; 0x5A (COMMIT) -> active <= shadow, commit_pulse next cycle, stay IDLE; 0xFF (IDENTITY) -> FILL; 0x00 (NOP) -> no effect; any other byte -> err_pulse, stay IDLE.
REQ-018 GET_DST: accepted byte latched as dst -> GET_SRC.
REQ-019 GET_SRC: accepted byte is src; if dst < OUTPUT_COUNT and src < INPUT_COUNT, shadow[dst] <= src[SEL_W-1:0]; otherwise err_pulse and no write; -> IDLE either way.
REQ-020 FILL: counter k steps 0..OUTPUT_COUNT-1, one entry per cycle, shadow[k] <= k mod INPUT_COUNT; in_ready = 0 throughout; -> IDLE after last entry; active unchanged.
REQ-021 in_ready = 1 in IDLE, GET_DST, GET_SRC; 0 in FILL.
REQ-022 Timeout counter resets on every accepted byte and on entering GET_DST; in GET_DST or GET_SRC, when TIMEOUT consecutive cycles pass without an accepted byte -> err_pulse, partial command discarded, -> IDLE.
REQ-023 SET writes shadow only; selectors change only on COMMIT, one cycle after the COMMIT byte is accepted, simultaneously with commit_pulse.
REQ-024 COMMIT immediately after SET commits the just-written entry (shadow write precedes commit in byte order).
REQ-025 commit_pulse and err_pulse are never high for more than one consecutive cycle per event; both low otherwise.
REQ-026 Back-to-back bytes (in_valid held high) are accepted every cycle with no bubbles outside FILL.

Reset
REQ-027 rst asserted at a clock edge: state <= IDLE, shadow and active <= identity (entry i = i mod INPUT_COUNT), timeout and fill counters <= 0.
REQ-028 Output reset values: selectors = identity, in_ready = 1, commit_pulse = 0, err_pulse = 0, busy = 0.
REQ-029 Reset mid-command or mid-FILL discards the command with no err_pulse.

Structure
REQ-030 Shared package mux_cfg_pkg holds command codes (CMD_SET 0xA5, CMD_COMMIT 0x5A, CMD_IDENTITY 0xFF, CMD_NOP 0x00) and the state enumeration.
REQ-031 Single sub-module mux_cfg_table: shadow/active register pair with indexed write port, commit strobe and identity reset.
REQ-032 Loader output feeds mux selectors with identical INPUT_COUNT/OUTPUT_COUNT; no glue logic.

Verification
REQ-033 Reset, then no input -> selectors bits [0:3]=0, [4:7]=1, ... [60:63]=15; busy=0, in_ready=1.
REQ-034 Bytes A5,03,0F,5A back-to-back -> selectors unchanged until the cycle after 5A; then field 3 = 15, all others identity; commit_pulse high exactly one cycle.
REQ-035 Bytes A5,10,02 (dst out of range) -> err_pulse one cycle, shadow unchanged; following 5A leaves selectors identity.
REQ-036 Bytes A5,05 then idle 1000 cycles -> err_pulse one cycle, busy falls; next A5,05,07,5A -> field 5 = 7.
REQ-037 Load a non-identity table, commit, send FF -> in_ready low 16 cycles, selectors unchanged; 5A -> selectors identity.
REQ-038 rst asserted while in GET_SRC or FILL -> next cycle state IDLE, selectors identity, no err_pulse, no commit_pulse.
